// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare, iterative shifter for
// SLL/SRL/SRA (SHIFT_STEP bits per cycle), valid/ready on both sides.
module alu_exec_unit #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Shift kind kept after accept: 01 SLL, 10 SRL, 11 SRA (low opcode bits).
  typedef struct packed {
    logic [1:0] kind;
    logic [4:0] rem;
  } shift_req_t;

  state_t           state, state_nxt;
  shift_req_t       sreq_q, sreq_nxt;
  logic [WIDTH-1:0] work_q, work_nxt;
  logic [WIDTH-1:0] result_q, result_nxt;
  logic             zero_q, zero_nxt;

  logic [WIDTH-1:0] alu_val;
  logic [WIDTH-1:0] shifted;
  logic [4:0]       k;
  logic             is_shift;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign zero      = zero_q;

  // Single-cycle datapath on the live inputs, used only at the accept edge.
  always_comb begin
    alu_val  = '0;
    is_shift = 1'b0;
    case (alu_control)
      OP_ADD:  alu_val = a + b;
      OP_SUB:  alu_val = a - b;
      OP_AND:  alu_val = a & b;
      OP_OR:   alu_val = a | b;
      OP_XOR:  alu_val = a ^ b;
      OP_SLL, OP_SRL, OP_SRA: is_shift = 1'b1;
      OP_SLT:  alu_val = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_val = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_val = '0;
    endcase
  end

  // One shifter step: k = min(SHIFT_STEP, remaining). SRA replicates the MSB,
  // which is still the original a[WIDTH-1] at every step.
  always_comb begin
    k = (sreq_q.rem < STEP) ? sreq_q.rem : STEP;
    case (sreq_q.kind)
      2'b01:   shifted = work_q << k;
      2'b10:   shifted = work_q >> k;
      default: shifted = WIDTH'($signed(work_q) >>> k);
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_nxt  = state;
    sreq_nxt   = sreq_q;
    work_nxt   = work_q;
    result_nxt = result_q;
    zero_nxt   = zero_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (is_shift && (b[4:0] != 5'd0)) begin
            work_nxt      = a;
            sreq_nxt.kind = alu_control[1:0];
            sreq_nxt.rem  = b[4:0];
            state_nxt     = SHIFT;
          end else begin
            result_nxt = is_shift ? a : alu_val;
            zero_nxt   = is_shift ? (a == '0) : (alu_val == '0);
            state_nxt  = DONE;
          end
        end
      end
      SHIFT: begin
        work_nxt     = shifted;
        sreq_nxt.rem = sreq_q.rem - k;
        if (sreq_q.rem == k) begin
          result_nxt = shifted;
          zero_nxt   = (shifted == '0);
          state_nxt  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sreq_q   <= '0;
      work_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      sreq_q   <= sreq_nxt;
      work_q   <= work_nxt;
      result_q <= result_nxt;
      zero_q   <= zero_nxt;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic clk, rst;
  logic        iv[2], ir[2], ov[2], ord[2], zr[2];
  logic [3:0]  ctl[2];
  logic [31:0] av[2], bv[2], res[2];
  int total, bad;
  localparam int STEPS[2] = '{1, 4};

  alu_exec_unit #(.WIDTH(32), .SHIFT_STEP(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .alu_control(ctl[0]), .a(av[0]), .b(bv[0]), .out_valid(ov[0]),
    .out_ready(ord[0]), .result(res[0]), .zero(zr[0]));

  alu_exec_unit #(.WIDTH(32), .SHIFT_STEP(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .alu_control(ctl[1]), .a(av[1]), .b(bv[1]), .out_valid(ov[1]),
    .out_ready(ord[1]), .result(res[1]), .zero(zr[1]));

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference: result straight from the opcode table.
  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    int sh;
    sh = int'(y % 32);
    case (op)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x & y;
      4'd3: return x | y;
      4'd4: return x ^ y;
      4'd5: return x << sh;
      4'd6: return x >> sh;
      4'd7: return $signed(x) >>> sh;
      4'd8: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd9: return (x < y) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Reference latency: 1 cycle, plus ceil(shamt/step) for a real shift.
  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] y, input int step);
    int sh;
    sh = int'(y % 32);
    if (op >= 4'd5 && op <= 4'd7 && sh > 0) return 1 + (sh + step - 1) / step;
    return 1;
  endfunction

  // Present one op, then scramble inputs and wait (bounded) for out_valid.
  task automatic do_op(input int s, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output logic [31:0] r, output logic z, output int ir_bad);
    int g;
    g = 0; ir_bad = 0;
    while (!ir[s] && g < 200) begin @(posedge clk); #1; g++; end
    ctl[s] = op; av[s] = x; bv[s] = y; iv[s] = 1;
    @(posedge clk); #1;
    iv[s] = 0; av[s] = $urandom; bv[s] = $urandom; ctl[s] = 4'($urandom);
    lat = 1;
    while (!ov[s] && lat < 200) begin
      if (ir[s]) ir_bad++;
      @(posedge clk); #1; lat++;
    end
    r = res[s]; z = zr[s];
  endtask

  task automatic release_op(input int s);
    ord[s] = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int s = 0; s < 2; s++) begin
      total++; if (ov[s] !== 1'b0) begin bad++; $display("FAIL reset_ov dut%0d got=%b exp=0", s, ov[s]); end
      total++; if (ir[s] !== 1'b1) begin bad++; $display("FAIL reset_ir dut%0d got=%b exp=1", s, ir[s]); end
      total++; if (res[s] !== 32'd0) begin bad++; $display("FAIL reset_res dut%0d got=%h exp=0", s, res[s]); end
      total++; if (zr[s] !== 1'b0) begin bad++; $display("FAIL reset_zero dut%0d got=%b exp=0", s, zr[s]); end
    end
  endtask

  task automatic test_add;
    int lat, irb; logic [31:0] r; logic z;
    do_op(0, 4'd0, 32'h7FFF_FFFF, 32'h1, lat, r, z, irb);
    total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL add_res got=%h exp=80000000", r); end
    total++; if (z !== 1'b0) begin bad++; $display("FAIL add_zero got=%b exp=0", z); end
    total++; if (lat !== 1) begin bad++; $display("FAIL add_lat got=%0d exp=1", lat); end
    release_op(0);
    total++; if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin bad++; $display("FAIL add_idle ir=%b ov=%b exp ir=1 ov=0", ir[0], ov[0]); end
  endtask

  task automatic test_compare;
    int lat, irb; logic [31:0] r; logic z;
    do_op(0, 4'd1, 32'd5, 32'd5, lat, r, z, irb);
    total++; if (r !== 32'd0 || z !== 1'b1) begin bad++; $display("FAIL sub_eq got=%h/%b exp=0/1", r, z); end
    release_op(0);
    do_op(0, 4'd8, 32'hFFFF_FFFF, 32'd1, lat, r, z, irb);
    total++; if (r !== 32'd1 || z !== 1'b0) begin bad++; $display("FAIL slt got=%h/%b exp=1/0", r, z); end
    release_op(0);
    do_op(0, 4'd9, 32'hFFFF_FFFF, 32'd1, lat, r, z, irb);
    total++; if (r !== 32'd0 || z !== 1'b1) begin bad++; $display("FAIL sltu got=%h/%b exp=0/1", r, z); end
    release_op(0);
  endtask

  task automatic test_shift;
    int lat, irb; logic [31:0] r; logic z;
    for (int s = 0; s < 2; s++) begin
      do_op(s, 4'd7, 32'h8000_0000, 32'd31, lat, r, z, irb);
      total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sra_res dut%0d got=%h exp=ffffffff", s, r); end
      total++; if (lat !== (s == 0 ? 32 : 9)) begin bad++; $display("FAIL sra_lat dut%0d got=%0d exp=%0d", s, lat, (s == 0 ? 32 : 9)); end
      total++; if (irb !== 0) begin bad++; $display("FAIL sra_busy dut%0d in_ready high %0d cycles exp=0", s, irb); end
      release_op(s);
    end
    do_op(0, 4'd5, 32'h1, 32'h20, lat, r, z, irb);
    total++; if (r !== 32'h1 || lat !== 1) begin bad++; $display("FAIL sll0 got=%h lat=%0d exp=1 lat=1", r, lat); end
    release_op(0);
    do_op(0, 4'd6, 32'hF0, 32'd4, lat, r, z, irb);
    total++; if (r !== 32'h0F || lat !== 5) begin bad++; $display("FAIL srl4 got=%h lat=%0d exp=f lat=5", r, lat); end
    release_op(0);
  endtask

  task automatic test_backpressure;
    int lat, irb, errs; logic [31:0] r; logic z;
    ord[0] = 0;
    do_op(0, 4'd4, 32'hA5A5_0000, 32'h0000_5A5A, lat, r, z, irb);
    total++; if (r !== 32'hA5A5_5A5A) begin bad++; $display("FAIL bp_res got=%h exp=a5a55a5a", r); end
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      iv[0] = 1; ctl[0] = 4'd0; av[0] = $urandom; bv[0] = $urandom;
      @(posedge clk); #1;
      if (res[0] !== 32'hA5A5_5A5A || zr[0] !== 1'b0 || ir[0] !== 1'b0 || ov[0] !== 1'b1) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL bp_hold unstable cycles got=%0d exp=0", errs); end
    iv[0] = 0;
    release_op(0);
    total++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin bad++; $display("FAIL bp_release ov=%b ir=%b exp ov=0 ir=1", ov[0], ir[0]); end
    do_op(0, 4'b1100, 32'h1234, 32'h5678, lat, r, z, irb);
    total++; if (r !== 32'd0 || z !== 1'b1 || lat !== 1) begin bad++; $display("FAIL op_undef got=%h/%b lat=%0d exp=0/1 lat=1", r, z, lat); end
    release_op(0);
  endtask

  task automatic test_reset_mid;
    int lat, irb; logic [31:0] r; logic z;
    ctl[0] = 4'd5; av[0] = 32'h3; bv[0] = 32'd20; iv[0] = 1;
    @(posedge clk); #1 iv[0] = 0;
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    total++; if (ov[0] !== 1'b0 || res[0] !== 32'd0 || ir[0] !== 1'b1) begin bad++; $display("FAIL rst_mid ov=%b res=%h ir=%b exp 0/0/1", ov[0], res[0], ir[0]); end
    do_op(0, 4'd0, 32'd2, 32'd3, lat, r, z, irb);
    total++; if (r !== 32'd5 || lat !== 1) begin bad++; $display("FAIL rst_add got=%h lat=%0d exp=5 lat=1", r, lat); end
    release_op(0);
  endtask

  task automatic test_random;
    int lat, irb; logic [31:0] r, x, y, er; logic z; logic [3:0] op;
    for (int i = 0; i < 80; i++) begin
      int s;
      s = i % 2;
      op = 4'($urandom_range(0, 15));
      x = $urandom; y = $urandom;
      if ($urandom_range(0, 3) == 0) x = y;
      do_op(s, op, x, y, lat, r, z, irb);
      er = ref_res(op, x, y);
      total++;
      if (r !== er || z !== (er == 32'd0) || lat !== ref_lat(op, y, STEPS[s])) begin
        bad++;
        $display("FAIL rand dut%0d op=%0d a=%h b=%h got=%h/%b lat=%0d exp=%h/%b lat=%0d",
                 s, op, x, y, r, z, lat, er, (er == 32'd0), ref_lat(op, y, STEPS[s]));
      end
      ord[s] = 0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 release_op(s);
    end
  endtask

  initial begin
    total = 0; bad = 0; rst = 1;
    for (int s = 0; s < 2; s++) begin
      iv[s] = 0; ord[s] = 1; ctl[s] = 0; av[s] = 0; bv[s] = 0;
    end
    test_reset;
    test_add;
    test_compare;
    test_shift;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit alu_control code from the ALU control decoder, plus two 32-bit operands. Returns the result and a zero flag through a valid/ready handshake.
- Logic, arithmetic and compare ops complete in one cycle.
- Shifts use an iterative shifter, SHIFT_STEP bit positions per cycle, to cut area ahead of the multicycle datapath work.
- Sits between operand/immediate muxing and the writeback/branch logic.

Parameters:
- WIDTH, 32, operand and result width; the shift amount is the low 5 bits of b.
- SHIFT_STEP, 1, bit positions shifted per cycle in SHIFT; legal values are 1, 2, 4, 8, 16.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation presented on alu_control/a/b.
- in_ready  output  1  unit can accept an operation; equals (state==IDLE).
- alu_control  input  4  operation code (encoding below).
- a  input  WIDTH  operand A (rs1).
- b  input  WIDTH  operand B (rs2 or immediate); b[4:0] is the shift amount.
- out_valid  output  1  result and zero are valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  registered result.
- zero  output  1  registered flag, (result==0).

Behaviour:
- Encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA.
  - 1000 SLT (signed), 1001 SLTU.
  - Codes 1010-1111 produce result 0, zero 1, with single-cycle timing.
- ADD/SUB wrap modulo 2^WIDTH; there is no overflow or carry output.
- SLT/SLTU produce 32'h0000_0001 or 32'h0000_0000.
- Accept: a transfer occurs on a cycle with in_valid && in_ready && !rst. Operands, opcode and shamt are latched at that edge; input changes afterwards have no effect.
- States:
  - IDLE: in_ready=1.
  - On accept of a non-shift op: compute the result at the accept edge and go to DONE.
  - On accept of a shift with shamt==0: result=a, go to DONE.
  - On accept of a shift with shamt>0: load the working register with a and the remaining count with shamt, go to SHIFT.
  - SHIFT: each cycle, shift the working register by k=min(SHIFT_STEP, remaining) and decrement remaining by k.
    - SLL and SRL fill with 0; SRA fills with a[WIDTH-1].
    - When remaining reaches 0 after the step, go to DONE with result = shifted value.
  - DONE: out_valid=1. result and zero hold stable until out_valid && out_ready; then go to IDLE.
- Latency, counted in cycles from the accept edge to out_valid:
  - Non-shift op or shamt 0: 1 cycle.
  - Shift with shamt>0: 1 + ceil(shamt/SHIFT_STEP) cycles.
- No new accept is possible while in DONE, even when out_ready=1. The minimum initiation interval is 2 cycles.
- Back-pressure: with out_ready=0 in DONE, the unit stalls indefinitely and holds all outputs.
- Reset:
  - rst=1 at any edge, including mid-SHIFT or in DONE, forces state IDLE, out_valid=0, result=0, zero=0, and clears the remaining count.
  - No operation is accepted on a reset cycle. An in-flight operation is discarded, not completed.
- zero is computed from the final result, including after the last shift step.

Test Plan:
- ADD 0x7FFF_FFFF + 0x0000_0001, out_ready=1 -> out_valid one cycle after accept, result 0x8000_0000, zero 0, in_ready back high the following cycle.
- SUB 5 - 5 (branch compare) -> result 0, zero 1. SLT a=0xFFFF_FFFF, b=1 -> 1. SLTU with the same operands -> 0.
- SRA a=0x8000_0000, b=31, SHIFT_STEP=1 -> in_ready low for 32 cycles, out_valid at cycle 32, result 0xFFFF_FFFF. Repeat with SHIFT_STEP=4 -> out_valid at cycle 9.
- SLL a=0x1, b=0x20 (shamt 0) -> 1-cycle latency, result 0x1. SRL a=0xF0, b=4 -> result 0x0F after 5 cycles (SHIFT_STEP=1).
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> result/zero stable, in_ready=0, in_valid ignored. Release out_ready -> one handshake, then IDLE. Also: opcode 1100 -> result 0, zero 1.
- Reset mid-shift: SLL shamt 20, assert rst at cycle 5 -> next cycle out_valid=0, result=0, in_ready=1. A new ADD 2+3 then returns 5 with 1-cycle latency.
